// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage: load-op encodings,
// FSM state type and the default reset PC.
package wb_pkg;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;
    localparam logic [2:0] LD_LWL = 3'd5;
    localparam logic [2:0] LD_LWR = 3'd6;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        StIdle,
        StWaitLd,
        StCommit
    } wb_state_e;

endpackage

// File: rtl/wb_load_fmt.sv
// Load data formatter: optional byte reversal of memory data, then byte/half
// selection with extension, or the LWL/LWR merge with the old rt value.
module wb_load_fmt
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter bit          BIG_ENDIAN_MEM = 1'b1
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        ld_op,
    input  logic [1:0]        addr_lo,
    input  logic              device,
    input  logic [DATA_W-1:0] rt,
    output logic [DATA_W-1:0] data
);

    logic [31:0] w;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Device space is already in CPU byte order.
        if (BIG_ENDIAN_MEM && !device) begin
            w = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
        end else begin
            w = rdata;
        end
        byte_sel = w[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? w[31:16] : w[15:0];

        data = '0;
        case (ld_op)
            LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: data = {24'h0, byte_sel};
            LD_LH:  data = {{16{half_sel[15]}}, half_sel};
            LD_LHU: data = {16'h0, half_sel};
            LD_LW:  data = w;
            LD_LWL: begin
                unique case (addr_lo)
                    2'd0: data = {w[7:0], rt[23:0]};
                    2'd1: data = {w[15:0], rt[15:0]};
                    2'd2: data = {w[23:0], rt[7:0]};
                    2'd3: data = w;
                endcase
            end
            LD_LWR: begin
                unique case (addr_lo)
                    2'd0: data = w;
                    2'd1: data = {rt[31:24], w[31:8]};
                    2'd2: data = {rt[31:16], w[31:16]};
                    2'd3: data = {rt[31:8], w[31:24]};
                endcase
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: registers the MEM/WB bundle, waits for late load
// data, and emits one-cycle commit pulses to GPR, HI/LO and CP0.
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int unsigned     DATA_W         = 32,
    parameter int unsigned     RA_W           = 5,
    parameter int unsigned     PC_W           = 32,
    parameter logic [PC_W-1:0] PC_INIT        = PC_W'(PC_INIT_DEFAULT),
    parameter bit              BIG_ENDIAN_MEM = 1'b1,
    parameter int unsigned     CNT_W          = 32
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_W-1:0]     in_pc,
    input  logic [RA_W-1:0]     in_wa,
    input  logic                in_wreg,
    input  logic                in_mreg,
    input  logic [2:0]          in_ld_op,
    input  logic [1:0]          in_addr_lo,
    input  logic                in_device,
    input  logic [DATA_W-1:0]   in_dreg,
    input  logic                in_whilo,
    input  logic [2*DATA_W-1:0] in_dhilo,
    input  logic                in_cp0_we,
    input  logic [RA_W-1:0]     in_cp0_waddr,
    input  logic [DATA_W-1:0]   in_cp0_wdata,
    input  logic                flush,
    input  logic                dm_rvalid,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic                wb_wreg_o,
    output logic [RA_W-1:0]     wb_wa_o,
    output logic [DATA_W-1:0]   wb_wd_o,
    output logic                wb_whilo_o,
    output logic [2*DATA_W-1:0] wb_hilo_o,
    output logic                cp0_we_o,
    output logic [RA_W-1:0]     cp0_waddr_o,
    output logic [DATA_W-1:0]   cp0_wdata_o,
    output logic [PC_W-1:0]     wb_pc_o,
    output logic                stall_o,
    output logic [CNT_W-1:0]    retire_cnt
);

    wb_state_e state_q;

    // Bundle held while a load waits for its data.
    logic [PC_W-1:0]     ld_pc_q;
    logic [RA_W-1:0]     ld_wa_q;
    logic                ld_wreg_q;
    logic [2:0]          ld_op_q;
    logic [1:0]          ld_addr_lo_q;
    logic                ld_device_q;
    logic [DATA_W-1:0]   ld_dreg_q;
    logic                ld_whilo_q;
    logic [2*DATA_W-1:0] ld_dhilo_q;
    logic                ld_cp0_we_q;
    logic [RA_W-1:0]     ld_cp0_waddr_q;
    logic [DATA_W-1:0]   ld_cp0_wdata_q;

    logic                wreg_q, whilo_q, cp0_we_q;
    logic [RA_W-1:0]     wa_q, cp0_waddr_q;
    logic [DATA_W-1:0]   wd_q, cp0_wdata_q;
    logic [2*DATA_W-1:0] hilo_q;
    logic [PC_W-1:0]     pc_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept, waiting, do_commit;
    logic [DATA_W-1:0]   fmt_data;

    logic                c_wreg, c_whilo, c_cp0_we;
    logic [RA_W-1:0]     c_wa, c_cp0_waddr;
    logic [DATA_W-1:0]   c_wd, c_cp0_wdata;
    logic [2*DATA_W-1:0] c_hilo;
    logic [PC_W-1:0]     c_pc;

    assign waiting  = (state_q == StWaitLd);
    assign in_ready = !waiting;
    assign stall_o  = waiting;
    assign accept   = in_valid && in_ready && !flush;

    // Flush beats dm_rvalid; dm_rvalid outside WAIT_LD is ignored.
    assign do_commit = waiting ? (dm_rvalid && !flush) : (accept && !in_mreg);

    wb_load_fmt #(
        .DATA_W         (DATA_W),
        .BIG_ENDIAN_MEM (BIG_ENDIAN_MEM)
    ) u_load_fmt (
        .rdata   (dm_rdata),
        .ld_op   (ld_op_q),
        .addr_lo (ld_addr_lo_q),
        .device  (ld_device_q),
        .rt      (ld_dreg_q),
        .data    (fmt_data)
    );

    always_comb begin
        c_wreg      = in_wreg;
        c_wa        = in_wa;
        c_wd        = in_dreg;
        c_whilo     = in_whilo;
        c_hilo      = in_dhilo;
        c_cp0_we    = in_cp0_we;
        c_cp0_waddr = in_cp0_waddr;
        c_cp0_wdata = in_cp0_wdata;
        c_pc        = in_pc;
        if (waiting) begin
            c_wreg      = ld_wreg_q;
            c_wa        = ld_wa_q;
            c_wd        = fmt_data;
            c_whilo     = ld_whilo_q;
            c_hilo      = ld_dhilo_q;
            c_cp0_we    = ld_cp0_we_q;
            c_cp0_waddr = ld_cp0_waddr_q;
            c_cp0_wdata = ld_cp0_wdata_q;
            c_pc        = ld_pc_q;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= StIdle;
            wreg_q      <= 1'b0;
            whilo_q     <= 1'b0;
            cp0_we_q    <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            hilo_q      <= '0;
            cp0_waddr_q <= '0;
            cp0_wdata_q <= '0;
            pc_q        <= PC_INIT;
            cnt_q       <= '0;
        end else begin
            wreg_q   <= 1'b0;
            whilo_q  <= 1'b0;
            cp0_we_q <= 1'b0;

            if (accept) begin
                ld_pc_q        <= in_pc;
                ld_wa_q        <= in_wa;
                ld_wreg_q      <= in_wreg;
                ld_op_q        <= in_ld_op;
                ld_addr_lo_q   <= in_addr_lo;
                ld_device_q    <= in_device;
                ld_dreg_q      <= in_dreg;
                ld_whilo_q     <= in_whilo;
                ld_dhilo_q     <= in_dhilo;
                ld_cp0_we_q    <= in_cp0_we;
                ld_cp0_waddr_q <= in_cp0_waddr;
                ld_cp0_wdata_q <= in_cp0_wdata;
            end

            if (do_commit) begin
                wreg_q      <= c_wreg;
                wa_q        <= c_wa;
                wd_q        <= c_wd;
                whilo_q     <= c_whilo;
                hilo_q      <= c_hilo;
                cp0_we_q    <= c_cp0_we;
                cp0_waddr_q <= c_cp0_waddr;
                cp0_wdata_q <= c_cp0_wdata;
                pc_q        <= c_pc;
                cnt_q       <= cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle, StCommit: begin
                    if (accept) state_q <= in_mreg ? StWaitLd : StCommit;
                    else        state_q <= StIdle;
                end
                StWaitLd: begin
                    if (flush)          state_q <= StIdle;
                    else if (dm_rvalid) state_q <= StCommit;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_wreg_o   = wreg_q;
    assign wb_wa_o     = wa_q;
    assign wb_wd_o     = wd_q;
    assign wb_whilo_o  = whilo_q;
    assign wb_hilo_o   = hilo_q;
    assign cp0_we_o    = cp0_we_q;
    assign cp0_waddr_o = cp0_waddr_q;
    assign cp0_wdata_o = cp0_wdata_q;
    assign wb_pc_o     = pc_q;
    assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage (2-bit retire counter to exercise wrap).
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        in_valid, in_ready, in_wreg, in_mreg, in_device, in_whilo, in_cp0_we;
    logic [31:0] in_pc, in_dreg, in_cp0_wdata, dm_rdata;
    logic [4:0]  in_wa, in_cp0_waddr;
    logic [2:0]  in_ld_op;
    logic [1:0]  in_addr_lo;
    logic [63:0] in_dhilo;
    logic        flush, dm_rvalid;
    logic        wb_wreg_o, wb_whilo_o, cp0_we_o, stall_o;
    logic [4:0]  wb_wa_o, cp0_waddr_o;
    logic [31:0] wb_wd_o, cp0_wdata_o, wb_pc_o;
    logic [63:0] wb_hilo_o;
    logic [1:0]  retire_cnt;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;
    logic [31:0] pc = 32'h0000_1000;

    always #5 clk = ~clk;

    wb_commit_stage #(.CNT_W(2)) dut (
        .cpu_clk      (clk),
        .cpu_rst      (cpu_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_wa        (in_wa),
        .in_wreg      (in_wreg),
        .in_mreg      (in_mreg),
        .in_ld_op     (in_ld_op),
        .in_addr_lo   (in_addr_lo),
        .in_device    (in_device),
        .in_dreg      (in_dreg),
        .in_whilo     (in_whilo),
        .in_dhilo     (in_dhilo),
        .in_cp0_we    (in_cp0_we),
        .in_cp0_waddr (in_cp0_waddr),
        .in_cp0_wdata (in_cp0_wdata),
        .flush        (flush),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .wb_wreg_o    (wb_wreg_o),
        .wb_wa_o      (wb_wa_o),
        .wb_wd_o      (wb_wd_o),
        .wb_whilo_o   (wb_whilo_o),
        .wb_hilo_o    (wb_hilo_o),
        .cp0_we_o     (cp0_we_o),
        .cp0_waddr_o  (cp0_waddr_o),
        .cp0_wdata_o  (cp0_wdata_o),
        .wb_pc_o      (wb_pc_o),
        .stall_o      (stall_o),
        .retire_cnt   (retire_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] p, input logic [4:0] wa, input logic mreg,
                        input logic [2:0] op, input logic [1:0] lo, input logic dev,
                        input logic [31:0] dreg);
        in_valid   = 1'b1;
        in_pc      = p;
        in_wa      = wa;
        in_wreg    = 1'b1;
        in_mreg    = mreg;
        in_ld_op   = op;
        in_addr_lo = lo;
        in_device  = dev;
        in_dreg    = dreg;
        in_whilo   = 1'b0;
        in_cp0_we  = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] op, input logic [1:0] lo,
                            input logic dev, input logic [31:0] rt, input logic [31:0] rdata,
                            input int gap, input logic [31:0] exp);
        pc = pc + 32'd4;
        send(pc, 5'd9, 1'b1, op, lo, dev, rt);
        tick;
        in_valid = 1'b0;
        chk({tag, "_stall"}, {63'd0, stall_o}, 64'd1);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < gap; i++) begin
            tick;
            chk({tag, "_stall_hold"}, {63'd0, stall_o}, 64'd1);
            chk({tag, "_ready_hold"}, {63'd0, in_ready}, 64'd0);
            chk({tag, "_nopulse"}, {63'd0, wb_wreg_o}, 64'd0);
        end
        dm_rvalid = 1'b1;
        dm_rdata  = rdata;
        tick;
        dm_rvalid = 1'b0;
        cnt++;
        chk({tag, "_wreg"}, {63'd0, wb_wreg_o}, 64'd1);
        chk({tag, "_wd"}, {32'd0, wb_wd_o}, {32'd0, exp});
        chk({tag, "_pc"}, {32'd0, wb_pc_o}, {32'd0, pc});
        chk({tag, "_cnt"}, {62'd0, retire_cnt}, 64'(cnt % 4));
    endtask

    initial begin
        cpu_rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_wa = '0; in_wreg = 1'b0;
        in_mreg = 1'b0; in_ld_op = '0; in_addr_lo = '0; in_device = 1'b0; in_dreg = '0;
        in_whilo = 1'b0; in_dhilo = '0; in_cp0_we = 1'b0; in_cp0_waddr = '0;
        in_cp0_wdata = '0; flush = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        tick;
        tick;
        cpu_rst = 1'b0;

        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_wreg", {63'd0, wb_wreg_o}, 64'd0);
        chk("rst_wd", {32'd0, wb_wd_o}, 64'd0);
        chk("rst_pc", {32'd0, wb_pc_o}, 64'hBFC0_0000);
        chk("rst_cnt", {62'd0, retire_cnt}, 64'd0);

        // ALU op with HI/LO and CP0 writes
        send(32'h0000_1000, 5'd5, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0000_1234);
        in_whilo = 1'b1; in_dhilo = 64'hDEAD_BEEF_0000_0001;
        in_cp0_we = 1'b1; in_cp0_waddr = 5'd12; in_cp0_wdata = 32'h0000_CAFE;
        tick;
        in_valid = 1'b0; in_whilo = 1'b0; in_cp0_we = 1'b0;
        cnt++;
        chk("alu_wreg", {63'd0, wb_wreg_o}, 64'd1);
        chk("alu_wa", {59'd0, wb_wa_o}, 64'd5);
        chk("alu_wd", {32'd0, wb_wd_o}, 64'h1234);
        chk("alu_whilo", {63'd0, wb_whilo_o}, 64'd1);
        chk("alu_hilo", wb_hilo_o, 64'hDEAD_BEEF_0000_0001);
        chk("alu_cp0we", {63'd0, cp0_we_o}, 64'd1);
        chk("alu_cp0a", {59'd0, cp0_waddr_o}, 64'd12);
        chk("alu_cp0d", {32'd0, cp0_wdata_o}, 64'hCAFE);
        chk("alu_pc", {32'd0, wb_pc_o}, 64'h1000);
        chk("alu_cnt", {62'd0, retire_cnt}, 64'd1);
        tick;
        chk("alu_wreg_drop", {63'd0, wb_wreg_o}, 64'd0);
        chk("alu_whilo_drop", {63'd0, wb_whilo_o}, 64'd0);
        chk("alu_cp0we_drop", {63'd0, cp0_we_o}, 64'd0);
        chk("alu_wd_hold", {32'd0, wb_wd_o}, 64'h1234);
        chk("alu_wa_hold", {59'd0, wb_wa_o}, 64'd5);

        // 32'h11803344 byte-reverses to 32'h44338011 for memory space
        load_chk("lb_mem_o1", 3'd0, 2'd1, 1'b0, 32'h0, 32'h1180_3344, 0, 32'hFFFF_FF80);
        load_chk("lb_mem_o2", 3'd0, 2'd2, 1'b0, 32'h0, 32'h1180_3344, 0, 32'h0000_0033);
        load_chk("lb_dev_o1", 3'd0, 2'd1, 1'b1, 32'h0, 32'h1180_3344, 0, 32'h0000_0033);
        load_chk("lb_dev_o2", 3'd0, 2'd2, 1'b1, 32'h0, 32'h1180_3344, 0, 32'hFFFF_FF80);
        load_chk("lbu_mem_o1", 3'd1, 2'd1, 1'b0, 32'h0, 32'h1180_3344, 0, 32'h0000_0080);
        load_chk("lh_mem_o2", 3'd2, 2'd2, 1'b0, 32'h0, 32'h1180_3344, 0, 32'h0000_4433);
        load_chk("lh_mem_o0", 3'd2, 2'd0, 1'b0, 32'h0, 32'h1180_3344, 0, 32'hFFFF_8011);
        load_chk("lhu_mem_o1", 3'd3, 2'd1, 1'b0, 32'h0, 32'h1180_3344, 0, 32'h0000_8011);
        load_chk("lw_mem", 3'd4, 2'd0, 1'b0, 32'h0, 32'h1180_3344, 0, 32'h4433_8011);
        load_chk("lw_dev", 3'd4, 2'd0, 1'b1, 32'h0, 32'h1180_3344, 0, 32'h1180_3344);
        // 32'h11223344 byte-reverses to 32'h44332211
        load_chk("lwl_o1", 3'd5, 2'd1, 1'b0, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h2211_CCDD);
        load_chk("lwl_o0", 3'd5, 2'd0, 1'b0, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h11BB_CCDD);
        load_chk("lwr_o2", 3'd6, 2'd2, 1'b0, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAABB_4433);
        load_chk("lwr_o3", 3'd6, 2'd3, 1'b0, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAABB_CC44);
        load_chk("ld_undef", 3'd7, 2'd0, 1'b0, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h0);
        load_chk("lw_gap3", 3'd4, 2'd0, 1'b0, 32'h0, 32'h1122_3344, 3, 32'h4433_2211);

        // dm_rvalid outside WAIT_LD does nothing
        tick;
        dm_rvalid = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        tick;
        dm_rvalid = 1'b0;
        chk("idle_rvalid_nopulse", {63'd0, wb_wreg_o}, 64'd0);
        chk("idle_rvalid_cnt", {62'd0, retire_cnt}, 64'(cnt % 4));

        // Flush wins over simultaneous dm_rvalid
        send(32'h0000_2000, 5'd7, 1'b1, 3'd4, 2'd0, 1'b0, 32'h0);
        tick;
        in_valid = 1'b0; flush = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h5555_5555;
        tick;
        flush = 1'b0; dm_rvalid = 1'b0;
        chk("flush_ld_nopulse", {63'd0, wb_wreg_o}, 64'd0);
        chk("flush_ld_cnt", {62'd0, retire_cnt}, 64'(cnt % 4));
        chk("flush_ld_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_ld_stall", {63'd0, stall_o}, 64'd0);
        tick;
        chk("flush_ld_late", {63'd0, wb_wreg_o}, 64'd0);

        // Flush blocks acceptance
        send(32'h0000_3000, 5'd8, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0000_BEEF);
        flush = 1'b1;
        tick;
        in_valid = 1'b0; flush = 1'b0;
        tick;
        chk("flush_in_nopulse", {63'd0, wb_wreg_o}, 64'd0);
        chk("flush_in_cnt", {62'd0, retire_cnt}, 64'(cnt % 4));
        chk("flush_in_pc", {32'd0, wb_pc_o}, {32'd0, pc});

        // Reset while a load is pending
        send(32'h0000_4000, 5'd3, 1'b1, 3'd4, 2'd0, 1'b0, 32'h0);
        tick;
        in_valid = 1'b0; cpu_rst = 1'b1; dm_rvalid = 1'b1;
        tick;
        cpu_rst = 1'b0; dm_rvalid = 1'b0;
        cnt = 0;
        chk("rstld_nopulse", {63'd0, wb_wreg_o}, 64'd0);
        chk("rstld_cnt", {62'd0, retire_cnt}, 64'd0);
        chk("rstld_stall", {63'd0, stall_o}, 64'd0);
        chk("rstld_pc", {32'd0, wb_pc_o}, 64'hBFC0_0000);
        tick;
        chk("rstld_late", {63'd0, wb_wreg_o}, 64'd0);

        // Back-to-back non-loads: counter 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            send(32'h0000_5000 + 32'(4 * i), 5'(i + 1), 1'b0, 3'd0, 2'd0, 1'b0,
                 32'h0000_1000 + 32'(i));
            tick;
            cnt++;
            chk("b2b_wreg", {63'd0, wb_wreg_o}, 64'd1);
            chk("b2b_wa", {59'd0, wb_wa_o}, 64'(i + 1));
            chk("b2b_wd", {32'd0, wb_wd_o}, 64'h1000 + 64'(i));
            chk("b2b_cnt", {62'd0, retire_cnt}, 64'(cnt % 4));
        end
        in_valid = 1'b0;
        tick;
        chk("b2b_end", {63'd0, wb_wreg_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
